// File: rtl/regfile_mp_if.sv
// Bundle of register-file write and read ports shared by regfile_mp and its clients.
interface regfile_mp_if #(
  parameter int N   = 32,
  parameter int R   = 5,
  parameter int NRD = 2
);
  logic             we_a;
  logic [R-1:0]     wa_a;
  logic [N-1:0]     wd_a;
  logic             we_b;
  logic [R-1:0]     wa_b;
  logic [N-1:0]     wd_b;
  logic [NRD*R-1:0] ra;
  logic [NRD*N-1:0] rd;
  logic             busy;
  logic             wr_conflict;

  modport master (
    output we_a, wa_a, wd_a, we_b, wa_b, wd_b, ra,
    input  rd, busy, wr_conflict
  );

  modport slave (
    input  we_a, wa_a, wd_a, we_b, wa_b, wd_b, ra,
    output rd, busy, wr_conflict
  );
endinterface

// File: rtl/regfile_mp.sv
// Dual-write, multi-read register file with hardware clear after reset.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
//
// state | meaning
// CLEAR | zeroing one entry per cycle; writes dropped, reads return 0
// READY | normal operation
module regfile_mp #(
  parameter int N   = 32,
  parameter int R   = 5,
  parameter int NRD = 2
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int         DEPTH = 1 << R;
  localparam logic [R:0] LAST  = (R+1)'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_e;

  state_e       state_q, state_d;
  logic [R:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         wr_conflict_q, wr_conflict_d;
  logic [N-1:0] mem_q [DEPTH];
  logic         wr_a, wr_b;
  logic [NRD*N-1:0] rd_all;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    busy_d        = busy_q;
    wr_conflict_d = 1'b0;
    wr_a          = 1'b0;
    wr_b          = 1'b0;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = READY;
          busy_d  = 1'b0;
        end
      end
      READY: begin
        wr_a          = bus.we_a && (bus.wa_a != '0);
        wr_b          = bus.we_b && (bus.wa_b != '0);
        wr_conflict_d = wr_a && wr_b && (bus.wa_a == bus.wa_b);
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CLEAR;
      cnt_q         <= '0;
      busy_q        <= 1'b1;
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      wr_conflict_q <= wr_conflict_d;
      if (state_q == CLEAR) begin
        mem_q[cnt_q[R-1:0]] <= '0;
      end else begin
        // B is written last so it wins when both ports hit the same entry
        if (wr_a) mem_q[bus.wa_a] <= bus.wd_a;
        if (wr_b) mem_q[bus.wa_b] <= bus.wd_b;
      end
    end
  end

  always_comb begin
    rd_all = '0;
    for (int k = 0; k < NRD; k++) begin
      logic [R-1:0] a;
      logic [N-1:0] v;
      a = bus.ra[k*R +: R];
      v = mem_q[a];
`ifdef REGFILE_BYPASS_EN
      if (wr_b && (bus.wa_b == a))      v = bus.wd_b;
      else if (wr_a && (bus.wa_a == a)) v = bus.wd_a;
`endif
      if (busy_q || (a == '0)) v = '0;
      rd_all[k*N +: N] = v;
    end
  end

  assign bus.rd          = rd_all;
  assign bus.busy        = busy_q;
  assign bus.wr_conflict = wr_conflict_q;
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file that succeeds the single-write, dual-read register file in the CPU datapath. It provides a configurable data width, address width and read-port count. It adds a second write port with fixed priority and a registered write-conflict flag. On reset it clears every entry in hardware, one entry per cycle, so the pipeline never reads stale data after reset. It sits between decode (read ports) and writeback (write ports A = ALU, B = load/store).

## Interface
- N, 32, data width in bits
- R, 5, address width; depth = 2**R entries; entry 0 hardwired to zero
- NRD, 2, number of read ports (≥1)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- we_a  in  1  write enable, port A
- wa_a  in  R  write address, port A
- wd_a  in  N  write data, port A
- we_b  in  1  write enable, port B
- wa_b  in  R  write address, port B
- wd_b  in  N  write data, port B
- ra  in  NRD*R  read addresses; port k occupies bits [k*R +: R]
- rd  out  NRD*N  read data; port k occupies bits [k*N +: N]
- busy  out  1  high while the hardware clear is in progress
- wr_conflict  out  1  registered; one-cycle pulse after both ports wrote the same nonzero address

## Operation
- FSM states: CLEAR, READY.
- rst=1 at an edge: state becomes CLEAR, clear counter cnt becomes 0, wr_conflict becomes 0. Array contents are untouched on that edge.
- CLEAR, rst=0 at an edge: entry cnt is written with 0 and cnt increments. The edge that clears entry 2**R−1 moves the FSM to READY.
- rst asserted mid-clear: cnt restarts at 0 and the full clear repeats.
- busy = 1 in CLEAR, 0 in READY.
- While busy, all writes are dropped and every rd port returns 0.
- READY writes:
  - A write is performed when weX=1 and waX≠0.
  - Writes to address 0 are discarded.
  - If both ports write the same address in one cycle, port B's data is stored.
  - If the addresses differ, both writes are stored.
- Reads are combinational. rd[k] = 0 when ra[k]=0; otherwise rd[k] = array[ra[k]] (subject to the bypass feature under Configuration).
- wr_conflict is set on the next edge when, in READY, we_a=we_b=1 and wa_a=wa_b≠0. Otherwise it is 0. It is diagnostic only and has no effect on stored data.
- Arithmetic: cnt is R+1 bits wide so the terminal count is detected without wrap. There is no width conversion on data.

## Timing
- Reset values: busy=1, wr_conflict=0, rd = all zeros.
- Clear duration is exactly 2**R cycles after the first edge with rst=0. For R=5 this is 32 cycles, and busy falls after the 32nd edge.
- Write latency: data is written on edge t and is visible on rd after edge t (without bypass).
- Read latency: 0 cycles (combinational from ra and array).
- wr_conflict: 1-cycle latency, 1-cycle pulse per conflicting cycle; back-to-back conflicts hold it high.
- A write in the same cycle that busy falls is dropped, because busy is still 1 before that edge.

## Configuration
- REGFILE_BYPASS_EN defined: read ports forward write data from the same cycle.
  - In READY, if ra[k]≠0 matches an enabled write, rd[k] returns that write's data.
  - Port B is forwarded when both ports match.
  - This gives same-cycle write→read visibility for the pipelined core.
- REGFILE_BYPASS_EN undefined: no forwarding. rd[k] returns the pre-edge array value.

## Test plan
- Reset/clear:
  - Stimulus: preload entry 7 = 0xDEADBEEF, pulse rst for 1 cycle.
  - Required: busy=1 for exactly 32 cycles; rd=0 throughout; entry 7 reads 0 once READY.
- Mid-clear reset:
  - Stimulus: rst at cycle 10 of the clear.
  - Required: busy remains 1 for 32 further cycles; all 32 entries read 0 afterwards.
- Dual write, distinct addresses:
  - Stimulus: A writes 3←0x11, B writes 4←0x22 in one cycle.
  - Required: next cycle, ra0=3 gives 0x11, ra1=4 gives 0x22; wr_conflict=0.
- Conflict:
  - Stimulus: A and B both write address 5 (0xAAAA, 0x5555).
  - Required: entry 5 = 0x5555; wr_conflict=1 for exactly one cycle.
- Zero register and busy drop:
  - Stimulus 1: write 0←0xFFFF.
  - Required: ra=0 gives 0.
  - Stimulus 2: write 9←0x1 while busy.
  - Required: entry 9 = 0 after clear.
- Bypass:
  - Stimulus: with entry 6 = 0x1, write 6←0x99 with ra0=6 in the same cycle.
  - Required: rd0=0x99 with REGFILE_BYPASS_EN; rd0=0x1 without it.
